// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter_if                                                    |
// | Writeback request, register-file write and commit-count bundle.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic [CNT_W-1:0]  commit_cnt0;
  logic [CNT_W-1:0]  commit_cnt1;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_write_enable, rf_write_addr, rf_write_data,
    input  commit_cnt0, commit_cnt1
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_write_enable, rf_write_addr, rf_write_data,
    output commit_cnt0, commit_cnt1
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter                                                       |
// | Round-robin share of the register-file write port between ALU and MEM.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_wb_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam logic [ADDR_W-1:0] c_zero_reg = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

  logic              r_last_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_commit0;
  logic              w_commit1;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_data;

  // On a conflict the port that did not win last time is served.
  always_comb begin
    w_grant0   = 1'b0;
    w_grant1   = 1'b0;
    w_win_addr = bus.req0_addr;
    w_win_data = bus.req0_data;
    if (!reset) begin
      w_grant0 = bus.req0_valid & (~bus.req1_valid | r_last_grant);
      w_grant1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
    end
    if (w_grant1) begin
      w_win_addr = bus.req1_addr;
      w_win_data = bus.req1_data;
    end
  end

  assign w_commit0 = w_grant0 & (bus.req0_addr != c_zero_reg);
  assign w_commit1 = w_grant1 & (bus.req1_addr != c_zero_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else begin
      r_we <= w_commit0 | w_commit1;
      if (w_commit0 | w_commit1) begin
        r_addr       <= w_win_addr;
        r_data       <= w_win_data;
        r_last_grant <= w_commit1;
      end
      if (w_commit0 && r_cnt0 != c_cnt_max) begin
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (w_commit1 && r_cnt1 != c_cnt_max) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
    end
  end

  assign bus.req0_ready      = w_grant0;
  assign bus.req1_ready      = w_grant1;
  // A write still staged when reset rises must not reach the register file.
  assign bus.rf_write_enable = r_we & ~reset;
  assign bus.rf_write_addr   = r_addr;
  assign bus.rf_write_data   = r_data;
  assign bus.commit_cnt0     = r_cnt0;
  assign bus.commit_cnt1     = r_cnt1;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_wb_arbiter                                                    |
// | Self-checking bench with a transaction-level reference model.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int CW   = 16;
  localparam int CW_S = 4;
  localparam int ZR   = 31;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW))   bus ();
  regfile_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW_S)) sbus ();

  regfile_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ZERO_REG(ZR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  regfile_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ZERO_REG(ZR), .CNT_W(CW_S)) dut_s (
    .clk(clk), .reset(reset), .bus(sbus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who was served last, the staged write, commit totals.
  int            m_last;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  longint        m_cnt [2];
  longint        c_cnt_cap = (64'd1 << CW) - 1;

  // Register file as seen from the write port.
  logic [DW-1:0] tb_rf [32];
  always @(posedge clk) if (bus.rf_write_enable === 1'b1) tb_rf[bus.rf_write_addr] <= bus.rf_write_data;

  task automatic drive0(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req0_valid = v; bus.req0_addr = a; bus.req0_data = d;
  endtask

  task automatic drive1(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req1_valid = v; bus.req1_addr = a; bus.req1_data = d;
  endtask

  task automatic idle();
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
  endtask

  function automatic int exp_grant();
    if (reset) return -1;
    if (bus.req0_valid && bus.req1_valid) return (m_last == 0) ? 1 : 0;
    if (bus.req0_valid) return 0;
    if (bus.req1_valid) return 1;
    return -1;
  endfunction

  task automatic advance();
    int            g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            rs;
    g  = exp_grant();
    a  = (g == 1) ? bus.req1_addr : bus.req0_addr;
    d  = (g == 1) ? bus.req1_data : bus.req0_data;
    rs = reset;
    @(posedge clk);
    if (rs) begin
      m_we = 0; m_addr = '0; m_data = '0; m_cnt[0] = 0; m_cnt[1] = 0; m_last = 1;
    end else if (g >= 0 && a != AW'(ZR)) begin
      m_we = 1; m_addr = a; m_data = d; m_last = g;
      if (m_cnt[g] < c_cnt_cap) m_cnt[g] = m_cnt[g] + 1;
    end else begin
      m_we = 0;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle();
    advance();
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive0(1'b1, 5'd4, 32'h4);
    drive1(1'b1, 5'd5, 32'h5);
    @(negedge clk);
    n_checks++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b want 0", bus.req0_ready); end
    n_checks++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready1: got %b want 0", bus.req1_ready); end
    advance();
    advance();
    n_checks++; if (bus.rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.rf_write_enable); end
    n_checks++; if (bus.rf_write_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.rf_write_addr); end
    n_checks++; if (bus.rf_write_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.rf_write_data); end
    n_checks++; if (bus.commit_cnt0 !== '0) begin n_fail++; $display("FAIL reset_cnt0: got %0d want 0", bus.commit_cnt0); end
    n_checks++; if (bus.commit_cnt1 !== '0) begin n_fail++; $display("FAIL reset_cnt1: got %0d want 0", bus.commit_cnt1); end
    idle();
    reset = 1'b0;
  endtask

  task automatic test_single();
    drive0(1'b1, 5'd3, 32'hA5A5_0001);
    @(negedge clk);
    n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready0: got %b want 1", bus.req0_ready); end
    n_checks++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready1: got %b want 0", bus.req1_ready); end
    advance();
    idle();
    n_checks++; if (bus.rf_write_enable !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", bus.rf_write_enable); end
    n_checks++; if (bus.rf_write_addr !== 5'd3) begin n_fail++; $display("FAIL single_addr: got %0d want 3", bus.rf_write_addr); end
    n_checks++; if (bus.rf_write_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_data: got %h want a5a50001", bus.rf_write_data); end
    n_checks++; if (bus.commit_cnt0 !== 16'd1) begin n_fail++; $display("FAIL single_cnt0: got %0d want 1", bus.commit_cnt0); end
    advance();
    n_checks++; if (bus.rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL single_idle_we: got %b want 0", bus.rf_write_enable); end
    n_checks++; if (bus.rf_write_addr !== 5'd3 || bus.rf_write_data !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL single_hold: got %0d/%h want 3/a5a50001", bus.rf_write_addr, bus.rf_write_data);
    end
  endtask

  task automatic test_alternate();
    logic [DW-1:0] d0, d1, want;
    apply_reset();
    d0 = 32'h100; d1 = 32'h200;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 5'd1, d0);
      drive1(1'b1, 5'd2, d1);
      @(negedge clk);
      n_checks++; if (bus.req0_ready !== (i % 2 == 0)) begin n_fail++; $display("FAIL alt_ready0[%0d]: got %b want %b", i, bus.req0_ready, (i % 2 == 0)); end
      n_checks++; if (bus.req1_ready !== (i % 2 == 1)) begin n_fail++; $display("FAIL alt_ready1[%0d]: got %b want %b", i, bus.req1_ready, (i % 2 == 1)); end
      want = (i % 2 == 0) ? d0 : d1;
      advance();
      n_checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_write_data !== want) begin
        n_fail++; $display("FAIL alt_write[%0d]: got we=%b data=%h want we=1 data=%h", i, bus.rf_write_enable, bus.rf_write_data, want);
      end
      if (i % 2 == 0) d0 = d0 + 1; else d1 = d1 + 1;
    end
    idle();
    n_checks++; if (bus.commit_cnt0 !== 16'd2) begin n_fail++; $display("FAIL alt_cnt0: got %0d want 2", bus.commit_cnt0); end
    n_checks++; if (bus.commit_cnt1 !== 16'd2) begin n_fail++; $display("FAIL alt_cnt1: got %0d want 2", bus.commit_cnt1); end
    advance();
  endtask

  task automatic test_zero_squash();
    drive0(1'b1, 5'd4, 32'h44);
    @(negedge clk);
    advance();
    idle();
    drive1(1'b1, 5'd31, 32'hDEAD);
    @(negedge clk);
    n_checks++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready1: got %b want 1", bus.req1_ready); end
    advance();
    idle();
    n_checks++; if (bus.rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL zero_we: got %b want 0", bus.rf_write_enable); end
    n_checks++; if (bus.commit_cnt1 !== m_cnt[1][CW-1:0]) begin n_fail++; $display("FAIL zero_cnt1: got %0d want %0d", bus.commit_cnt1, m_cnt[1]); end
    // Port 0 won last; the squashed port-1 request must not have taken that over.
    drive0(1'b1, 5'd5, 32'h55);
    drive1(1'b1, 5'd6, 32'h66);
    @(negedge clk);
    n_checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL zero_last_grant: got ready0=%b ready1=%b want 0/1", bus.req0_ready, bus.req1_ready);
    end
    advance();
    idle();
    n_checks++; if (bus.rf_write_data !== 32'h66) begin n_fail++; $display("FAIL zero_next_data: got %h want 66", bus.rf_write_data); end
    advance();
  endtask

  task automatic test_same_addr();
    apply_reset();
    drive0(1'b1, 5'd7, 32'd1);
    drive1(1'b1, 5'd7, 32'd2);
    @(negedge clk);
    n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL same_first_grant: got %b want 1", bus.req0_ready); end
    advance();
    drive0(1'b0, '0, '0);
    n_checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_write_addr !== 5'd7 || bus.rf_write_data !== 32'd1) begin
      n_fail++; $display("FAIL same_write1: got %b/%0d/%h want 1/7/1", bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data);
    end
    @(negedge clk);
    n_checks++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL same_second_grant: got %b want 1", bus.req1_ready); end
    advance();
    idle();
    n_checks++; if (bus.rf_write_enable !== 1'b1 || bus.rf_write_addr !== 5'd7 || bus.rf_write_data !== 32'd2) begin
      n_fail++; $display("FAIL same_write2: got %b/%0d/%h want 1/7/2", bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data);
    end
    advance();
    n_checks++; if (tb_rf[7] !== 32'd2) begin n_fail++; $display("FAIL same_final_reg7: got %h want 2", tb_rf[7]); end
  endtask

  task automatic test_reset_mid();
    drive0(1'b1, 5'd9, 32'h99);
    @(negedge clk);
    advance();
    idle();
    reset = 1'b1;
    #1;
    n_checks++; if (bus.rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL mid_we_during: got %b want 0", bus.rf_write_enable); end
    advance();
    n_checks++; if (bus.rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL mid_we_reset: got %b want 0", bus.rf_write_enable); end
    n_checks++; if (bus.commit_cnt0 !== '0 || bus.commit_cnt1 !== '0) begin
      n_fail++; $display("FAIL mid_cnts: got %0d/%0d want 0/0", bus.commit_cnt0, bus.commit_cnt1);
    end
    reset = 1'b0;
    advance();
    n_checks++; if (bus.rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL mid_we_after: got %b want 0", bus.rf_write_enable); end
    n_checks++; if (tb_rf[9] !== '0) begin n_fail++; $display("FAIL mid_discarded: got %h want 0", tb_rf[9]); end
  endtask

  task automatic test_random();
    bit p0, p1;
    int g;
    apply_reset();
    p0 = 0; p1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p0) drive0($urandom_range(2) != 0, ($urandom_range(5) == 0) ? AW'(ZR) : AW'($urandom_range(30)), $urandom);
      if (!p1) drive1($urandom_range(2) != 0, ($urandom_range(5) == 0) ? AW'(ZR) : AW'($urandom_range(30)), $urandom);
      @(negedge clk);
      g = exp_grant();
      n_checks++; if (bus.req0_ready !== (g == 0)) begin n_fail++; $display("FAIL rand_ready0[%0d]: got %b want %b", i, bus.req0_ready, (g == 0)); end
      n_checks++; if (bus.req1_ready !== (g == 1)) begin n_fail++; $display("FAIL rand_ready1[%0d]: got %b want %b", i, bus.req1_ready, (g == 1)); end
      p0 = bus.req0_valid && g != 0;
      p1 = bus.req1_valid && g != 1;
      advance();
      n_checks++; if (bus.rf_write_enable !== m_we) begin n_fail++; $display("FAIL rand_we[%0d]: got %b want %b", i, bus.rf_write_enable, m_we); end
      n_checks++; if (bus.rf_write_addr !== m_addr || bus.rf_write_data !== m_data) begin
        n_fail++; $display("FAIL rand_wr[%0d]: got %0d/%h want %0d/%h", i, bus.rf_write_addr, bus.rf_write_data, m_addr, m_data);
      end
      n_checks++; if (bus.commit_cnt0 !== m_cnt[0][CW-1:0] || bus.commit_cnt1 !== m_cnt[1][CW-1:0]) begin
        n_fail++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i, bus.commit_cnt0, bus.commit_cnt1, m_cnt[0], m_cnt[1]);
      end
    end
    idle();
    advance();
  endtask

  task automatic test_saturate();
    int want;
    apply_reset();
    for (int n = 1; n <= (1 << CW_S) + 3; n++) begin
      sbus.req0_valid = 1'b1;
      sbus.req0_addr  = AW'(n % 30 + 1);
      sbus.req0_data  = DW'(n);
      @(negedge clk);
      n_checks++; if (sbus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL sat_ready[%0d]: got %b want 1", n, sbus.req0_ready); end
      advance();
      want = (n < 15) ? n : 15;
      n_checks++; if (sbus.commit_cnt0 !== CW_S'(want) || sbus.rf_write_enable !== 1'b1) begin
        n_fail++; $display("FAIL sat_cnt0[%0d]: got cnt=%0d we=%b want cnt=%0d we=1", n, sbus.commit_cnt0, sbus.rf_write_enable, want);
      end
    end
    sbus.req0_valid = 1'b0;
    advance();
    n_checks++; if (sbus.commit_cnt0 !== 4'd15 || sbus.rf_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL sat_hold: got cnt=%0d we=%b want 15/0", sbus.commit_cnt0, sbus.rf_write_enable);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) tb_rf[i] = '0;
    idle();
    sbus.req0_valid = 1'b0; sbus.req0_addr = '0; sbus.req0_data = '0;
    sbus.req1_valid = 1'b0; sbus.req1_addr = '0; sbus.req1_data = '0;
    m_last = 1; m_we = 0; m_addr = '0; m_data = '0; m_cnt[0] = 0; m_cnt[1] = 0;
    test_reset();
    test_single();
    test_alternate();
    test_zero_squash();
    test_same_addr();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
